// File: rtl/alu_pkt_builder.sv
// Builds Avalon-ST packets from a command (header beat) followed by cmd_len
// operand pairs (body beats), all emitted through one registered output stage.
module alu_pkt_builder #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_opcode,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             opnd_valid,
  input  logic [15:0]      opnd_a,
  input  logic [15:0]      opnd_b,
  output logic             opnd_ready,
  input  logic             src_ready,
  output logic             src_valid,
  output logic             src_sop,
  output logic             src_eop,
  output logic [31:0]      src_data,
  output logic             pkt_done,
  output logic [15:0]      pkt_cnt
);

  typedef enum logic {IDLE, BODY} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             src_valid_q, src_valid_d;
  logic             src_sop_q, src_sop_d;
  logic             src_eop_q, src_eop_d;
  logic [31:0]      src_data_q, src_data_d;
  logic             pkt_done_q, pkt_done_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;

  logic slot_free;
  logic cmd_fire;
  logic opnd_fire;
  logic src_xfer;

  // The output register may be reloaded whenever it is empty or draining this cycle.
  assign slot_free  = !src_valid_q || src_ready;
  assign cmd_ready  = !rst && (state_q == IDLE) && slot_free;
  assign opnd_ready = !rst && (state_q == BODY) && slot_free;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign opnd_fire  = opnd_valid && opnd_ready;
  assign src_xfer   = src_valid_q && src_ready;

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    src_valid_d = src_valid_q && !src_xfer;
    src_sop_d   = src_sop_q;
    src_eop_d   = src_eop_q;
    src_data_d  = src_data_q;
    pkt_done_d  = src_xfer && src_eop_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (pkt_done_d) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    if (cmd_fire) begin
      src_valid_d = 1'b1;
      src_sop_d   = 1'b1;
      src_eop_d   = (cmd_len == '0);
      src_data_d  = {30'b0, cmd_opcode};
      rem_d       = cmd_len;
      state_d     = (cmd_len == '0) ? IDLE : BODY;
    end else if (opnd_fire) begin
      src_valid_d = 1'b1;
      src_sop_d   = 1'b0;
      src_eop_d   = (rem_q == LEN_W'(1));
      src_data_d  = {opnd_a, opnd_b};
      rem_d       = rem_q - LEN_W'(1);
      if (rem_q == LEN_W'(1)) begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears the
  // datapath too so an aborted beat can never leak out after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_data_q  <= '0;
      pkt_done_q  <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      src_valid_q <= src_valid_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
      src_data_q  <= src_data_d;
      pkt_done_q  <= pkt_done_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign src_valid = src_valid_q;
  assign src_sop   = src_sop_q;
  assign src_eop   = src_eop_q;
  assign src_data  = src_data_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_alu_pkt_builder.sv
// Self-checking bench for alu_pkt_builder: expected beat stream is built per
// packet from the commands/operands the bench sends, then matched on each transfer.
module tb_alu_pkt_builder;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [1:0]       cmd_opcode;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             opnd_valid;
  logic [15:0]      opnd_a;
  logic [15:0]      opnd_b;
  logic             opnd_ready;
  logic             src_ready;
  logic             src_valid;
  logic             src_sop;
  logic             src_eop;
  logic [31:0]      src_data;
  logic             pkt_done;
  logic [15:0]      pkt_cnt;

  always #5 clk = ~clk;

  alu_pkt_builder #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_opcode (cmd_opcode),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .opnd_valid (opnd_valid),
    .opnd_a     (opnd_a),
    .opnd_b     (opnd_b),
    .opnd_ready (opnd_ready),
    .src_ready  (src_ready),
    .src_valid  (src_valid),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_data   (src_data),
    .pkt_done   (pkt_done),
    .pkt_cnt    (pkt_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
  } cmd_t;

  beat_t       exp_q[$];
  cmd_t        cmd_q[$];
  logic [31:0] opnd_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          body_pend = 0;
  int          body_left = 0;
  int          stray_pct = 0;
  int          cyc = 0;
  int          nbeats = 0;
  int          first_x = -1;
  int          last_x = -1;
  bit          in_body = 1'b0;
  logic [15:0] exp_cnt = '0;

  bit          prev_fire = 1'b0;
  bit          prev_xfer = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_eop_xfer = 1'b0;
  bit          prev_rst = 1'b0;
  logic [2:0]  prev_flags = '0;
  logic [31:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Header beat of a new packet; body beats follow via push_opnd.
  task automatic push_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len);
    cmd_t  c;
    beat_t b;
    c.op   = op;
    c.len  = len;
    cmd_q.push_back(c);
    b.data = {30'b0, op};
    b.sop  = 1'b1;
    b.eop  = (len == '0);
    exp_q.push_back(b);
    body_pend = int'(len);
  endtask

  task automatic push_opnd(input logic [15:0] a, input logic [15:0] b_in);
    beat_t b;
    opnd_q.push_back({a, b_in});
    body_pend--;
    b.data = {a, b_in};
    b.sop  = 1'b0;
    b.eop  = (body_pend == 0);
    exp_q.push_back(b);
  endtask

  task automatic push_pkt(input logic [1:0] op, input int len);
    push_cmd(op, LEN_W'(len));
    for (int i = 0; i < len; i++) push_opnd(16'($urandom), 16'($urandom));
  endtask

  // One clock: drive at the falling edge, sample 1ns later, account for the
  // events that the next rising edge will commit.
  task automatic cycle(input bit rdy, input int valid_pct);
    bit    stall;
    bit    cfire;
    bit    ofire;
    bit    xfer;
    bit    eop_x;
    beat_t e;

    src_ready = rdy;
    if (!in_body) begin
      cmd_valid = (cmd_q.size() > 0) && ($urandom_range(99) < valid_pct);
      if (cmd_valid) begin
        cmd_opcode = cmd_q[0].op;
        cmd_len    = cmd_q[0].len;
      end else begin
        cmd_opcode = 2'($urandom);
        cmd_len    = LEN_W'($urandom);
      end
      opnd_valid = ($urandom_range(99) < stray_pct);
      opnd_a     = 16'($urandom);
      opnd_b     = 16'($urandom);
    end else begin
      opnd_valid = (opnd_q.size() > 0) && ($urandom_range(99) < valid_pct);
      if (opnd_valid) begin
        opnd_a = opnd_q[0][31:16];
        opnd_b = opnd_q[0][15:0];
      end else begin
        opnd_a = 16'($urandom);
        opnd_b = 16'($urandom);
      end
      cmd_valid  = ($urandom_range(99) < stray_pct);
      cmd_opcode = 2'($urandom);
      cmd_len    = LEN_W'($urandom);
    end
    #1;

    if (prev_rst) begin
      check("rst_src_valid", src_valid, 0);
      check("rst_src_flags", {src_sop, src_eop}, 0);
      check("rst_src_data", src_data, 0);
      check("rst_pkt_done", pkt_done, 0);
      check("rst_pkt_cnt", pkt_cnt, 0);
    end else begin
      if (prev_fire) check("latency_valid", src_valid, 1);
      else if (prev_xfer) check("valid_fall", src_valid, 0);
      if (prev_stall) begin
        check("stall_flags", {src_valid, src_sop, src_eop}, prev_flags);
        check("stall_data", src_data, prev_data);
      end
      check("pkt_done", pkt_done, prev_eop_xfer);
      check("pkt_cnt", pkt_cnt, exp_cnt);
    end

    stall = src_valid && !src_ready;
    check("cmd_ready", cmd_ready, !rst && !in_body && !stall);
    check("opnd_ready", opnd_ready, !rst && in_body && !stall);

    cfire = !rst && !in_body && cmd_valid && cmd_ready && (cmd_q.size() > 0);
    ofire = !rst && in_body && opnd_valid && opnd_ready && (opnd_q.size() > 0);
    xfer  = !rst && src_valid && src_ready;
    eop_x = 1'b0;

    if (xfer) begin
      nbeats++;
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", src_data, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", src_data, e.data);
        check("beat_sop_eop", {src_sop, src_eop}, {e.sop, e.eop});
        eop_x = e.eop;
        if (e.eop) exp_cnt = exp_cnt + 16'd1;
      end
    end

    if (cfire) begin
      if (cmd_q[0].len != '0) begin
        in_body   = 1'b1;
        body_left = int'(cmd_q[0].len);
      end
      void'(cmd_q.pop_front());
    end
    if (ofire) begin
      void'(opnd_q.pop_front());
      body_left--;
      if (body_left == 0) in_body = 1'b0;
    end

    if (rst) begin
      cmd_q.delete();
      opnd_q.delete();
      exp_q.delete();
      in_body   = 1'b0;
      body_left = 0;
      body_pend = 0;
      exp_cnt   = '0;
    end

    prev_fire     = cfire || ofire;
    prev_xfer     = xfer;
    prev_stall    = !rst && stall;
    prev_eop_xfer = xfer && eop_x;
    prev_rst      = rst;
    prev_flags    = {src_valid, src_sop, src_eop};
    prev_data     = src_data;

    @(negedge clk);
    cyc++;
  endtask

  // Run until everything queued has been sent and received, within a budget.
  task automatic run(input int rdy_pct, input int valid_pct, input int budget, input bit check_tput);
    int n0;
    int k;
    n0      = nbeats;
    first_x = -1;
    last_x  = -1;
    k       = 0;
    while ((cmd_q.size() > 0 || opnd_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
      cycle($urandom_range(99) < rdy_pct, valid_pct);
      k++;
    end
    if (k >= budget) begin
      check("timeout", 1, 0);
      cmd_q.delete();
      opnd_q.delete();
      exp_q.delete();
    end
    if (check_tput) check("no_bubble", last_x - first_x, nbeats - n0 - 1);
    cycle(1'b1, 100);
    cycle(1'b1, 100);
  endtask

  initial begin
    int n0;
    int k;

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_len    = '0;
    opnd_valid = 1'b0;
    opnd_a     = '0;
    opnd_b     = '0;
    src_ready  = 1'b0;
    repeat (2) @(negedge clk);
    prev_rst = 1'b1;
    cycle(1'b1, 100);
    rst = 1'b0;
    cycle(1'b1, 100);

    // Basic packet.
    push_cmd(2'd1, LEN_W'(2));
    push_opnd(16'h0003, 16'h0005);
    push_opnd(16'hFFFF, 16'h0001);
    run(100, 100, 50, 1'b1);
    check("basic_pkt_cnt", pkt_cnt, 16'd1);

    // Zero-length command.
    push_cmd(2'd3, LEN_W'(0));
    run(100, 100, 50, 1'b1);
    check("zero_len_pkt_cnt", pkt_cnt, 16'd2);

    // Backpressure on the header for three cycles.
    push_pkt(2'd1, 2);
    cycle(1'b1, 100);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 100);
      check("bp_header_held", {src_valid, src_sop}, 2'b11);
    end
    run(100, 100, 50, 1'b0);

    // Back-to-back packets.
    push_pkt(2'd2, 1);
    push_pkt(2'd0, 1);
    run(100, 100, 50, 1'b1);
    check("b2b_pkt_cnt", pkt_cnt, 16'd5);

    // Operands presented while idle must be ignored.
    stray_pct = 100;
    repeat (5) cycle(1'b1, 100);
    check("stray_no_beat", src_valid, 0);
    stray_pct = 0;

    // Reset after the second body beat of a four-beat body.
    push_pkt(2'd2, 4);
    n0 = nbeats;
    k  = 0;
    while (nbeats - n0 < 3 && k < 20) begin
      cycle(1'b1, 100);
      k++;
    end
    check("pre_rst_beats", nbeats - n0, 3);
    rst = 1'b1;
    cycle(1'b1, 100);
    rst = 1'b0;
    push_pkt(2'd0, 1);
    run(100, 100, 50, 1'b1);
    check("post_rst_pkt_cnt", pkt_cnt, 16'd1);

    // Maximum length body.
    push_pkt(2'd2, (1 << LEN_W) - 1);
    run(100, 100, 600, 1'b1);
    check("max_len_pkt_cnt", pkt_cnt, 16'd2);

    // Randomized traffic with backpressure, gaps and wrong-state inputs.
    stray_pct = 30;
    for (int p = 0; p < 40; p++) begin
      push_pkt(2'($urandom), ($urandom_range(9) == 0) ? 0 : int'($urandom_range(9)));
    end
    run(60 + int'($urandom_range(40)), 50 + int'($urandom_range(50)), 3000, 1'b0);
    check("rand_pkt_cnt", pkt_cnt, 16'd42);
    stray_pct = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pkt_builder.md
ALU_PKT_BUILDER -- requirements
Module: alu_pkt_builder

Interface
REQ-001 Parameter LEN_W, default 8: width of the command length field, i.e. the operand-word count per packet.
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_opcode  in  2  0=ADD, 1=XOR, 2=AND, 3=OR.
REQ-006 cmd_len  in  LEN_W  number of operand words that follow the header (0 allowed).
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 opnd_valid  in  1  operand pair valid.
REQ-009 opnd_a  in  16  first operand.
REQ-010 opnd_b  in  16  second operand.
REQ-011 opnd_ready  out  1  operand pair accepted when opnd_valid and opnd_ready are both high.
REQ-012 src_ready  in  1  Avalon-ST sink ready, ready_latency = 0.
REQ-013 src_valid, src_sop, src_eop  out  1 each  Avalon-ST source qualifiers.
REQ-014 src_data  out  32  Avalon-ST source data.
REQ-015 pkt_done  out  1  one-cycle pulse when an eop beat is transferred.
REQ-016 pkt_cnt  out  16  count of completed packets, wraps modulo 2^16.

Function
REQ-017 The block SHALL emit packets of the form: one header beat, then cmd_len body beats.
  - Header beat: src_sop=1, src_data={30'b0, opcode}.
  - Body beat: src_data={opnd_a, opnd_b}, with opnd_a in [31:16] and opnd_b in [15:0].
REQ-018 All src_* outputs SHALL be driven from a single output register stage.
  - A beat transfers on a cycle where src_valid=1 and src_ready=1.
  - While src_valid=1 and src_ready=0, all src_* outputs SHALL hold stable.
REQ-019 Define slot_free = !src_valid || src_ready, evaluated combinationally in the same cycle.
REQ-020 The FSM SHALL have two states, IDLE and BODY.
  - cmd_ready = (IDLE && slot_free).
  - opnd_ready = (BODY && slot_free).
  - Neither ready signal SHALL depend on cmd_valid or opnd_valid.
REQ-021 Command accepted in IDLE: load the header beat (src_eop = (cmd_len==0)) and set remaining=cmd_len.
  - Next state BODY if cmd_len != 0, otherwise stay in IDLE.
REQ-022 Operand accepted in BODY: load the body beat with src_eop = (remaining==1), then decrement remaining.
  - On remaining==1, return to IDLE.
REQ-023 When a transfer occurs and no new beat is loaded in the same cycle, src_valid SHALL fall to 0 on the next edge.
REQ-024 Latency SHALL be one cycle from acceptance on cmd/opnd to the beat appearing on src.
  - With src_ready held high, sustained throughput SHALL be one beat per cycle, including header-to-body and eop-to-next-header with no bubble.
REQ-025 Inputs presented in the wrong state SHALL be ignored with no side effects.
  - opnd_valid in IDLE and cmd_valid in BODY are ignored; the matching ready stays 0.
REQ-026 cmd_len==0 SHALL produce a single beat with src_sop=1 and src_eop=1.
REQ-027 Maximum cmd_len (2^LEN_W-1) SHALL produce exactly that many body beats with no counter wrap.
REQ-028 On transfer of a beat with src_eop=1, pkt_done SHALL pulse high for the following cycle and pkt_cnt SHALL increment, wrapping 0xFFFF to 0x0000.
REQ-029 The block SHALL perform no arithmetic on operands; they are packed unchanged.

Reset
REQ-030 While rst=1, the block SHALL force the following on the next edge:
  - src_valid=0, src_sop=0, src_eop=0, src_data=0;
  - pkt_done=0, pkt_cnt=0;
  - state=IDLE, remaining=0.
REQ-031 While rst=1, cmd_ready and opnd_ready SHALL be 0.
REQ-032 Reset asserted mid-packet SHALL abort that packet.
  - No eop is emitted for it.
  - The pending output beat is discarded.
  - The first packet after reset starts with a fresh header.

Verification
REQ-033 Basic packet, src_ready=1: cmd (opcode=1, len=2), then operands (0x0003,0x0005) and (0xFFFF,0x0001).
  - Required: src beats 0x00000001 (sop), 0x00030005, 0xFFFF0001 (eop) on consecutive cycles.
  - Required: pkt_done pulses once and pkt_cnt=1.
REQ-034 Zero-length command: cmd (opcode=3, len=0).
  - Required: one beat 0x00000003 with sop=1 and eop=1; cmd_ready is high again on the next cycle.
REQ-035 Backpressure: src_ready low for 3 cycles while the header is valid.
  - Required: src_* stable for all 3 cycles and opnd_ready=0 throughout.
  - Required: body beats resume after src_ready rises, with no beat lost or duplicated.
REQ-036 Back-to-back packets: two cmds of len=1 with src_ready=1.
  - Required: 4 beats with no bubble, sop/eop flags correct on each, pkt_cnt=2.
REQ-037 Wrong-state input: opnd_valid=1 in IDLE.
  - Required: opnd_ready=0 and no src beat produced.
REQ-038 Reset mid-packet: cmd len=4, rst asserted after the 2nd body beat.
  - Required: src_valid=0 the cycle after rst.
  - Required: a following cmd (opcode=0, len=1) yields a fresh sop header.
